// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//
// Physical-register free list for a renaming pipeline. It holds 32 seven-bit
// physical tags in a circular buffer. Dispatch pops one tag from the head.
// Retire pushes a stale tag at the tail. A mispredicted branch rewinds the
// head to a checkpoint that the branch stack supplies.
//
// Ports
//   clk             system clock; all state updates on the rising edge
//   rst             asynchronous, active-low reset
//   dispatch_en_i   request one free tag this cycle (pop)
//   retire_en_i     return a stale tag this cycle (push)
//   retire_tag_i    the stale tag being returned
//   br_state_i      branch resolution state; `BR_PR_WRONG means recover
//   rc_fl_head_i    checkpointed head to restore on recovery
//   free_tag_o      tag at the current head (what dispatch receives)
//   free_valid_o    free_tag_o is valid (list not empty)
//   head_o          current head pointer (branch-stack checkpoint source)
//   free_cnt_o      number of free tags, 0..32
//   full_o          free_cnt_o == 32
// ---------------------------------------------------------------------------

`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif

`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module free_list (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_en_i,
  input  logic                   retire_en_i,
  input  logic [6:0]             retire_tag_i,
  input  logic [`BR_STATE_W-1:0] br_state_i,
  input  logic [4:0]             rc_fl_head_i,
  output logic [6:0]             free_tag_o,
  output logic                   free_valid_o,
  output logic [4:0]             head_o,
  output logic [5:0]             free_cnt_o,
  output logic                   full_o
);

  localparam int unsigned DEPTH = 32;

  // Storage and pointers
  logic [6:0] entry_q [DEPTH];
  logic [4:0] head_q, head_d;
  logic [4:0] tail_q, tail_d;
  logic [5:0] cnt_q,  cnt_d;

  // Qualified events for this cycle
  logic recover;
  logic pop;
  logic push;
  logic [4:0] rewind;

  assign recover = (br_state_i == `BR_PR_WRONG);
  assign pop     = dispatch_en_i & free_valid_o & ~recover;
  assign push    = retire_en_i & ~full_o;

  // The tags between the checkpoint and the current head were handed out
  // to instructions that are now squashed. The modular distance counts
  // them. It cannot reach 32 because the ROB never holds that many
  // instructions younger than a branch.
  assign rewind = head_q - rc_fl_head_i;

  // NOTE: a combinational block assigns every output on every path (the
  // defaults come first), so that no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;

    if (push) begin
      tail_d = tail_q + 5'd1;
    end

    if (recover) begin
      head_d = rc_fl_head_i;
      cnt_d  = cnt_q + {1'b0, rewind} + {5'd0, push};
    end else begin
      if (pop) begin
        head_d = head_q + 5'd1;
      end
      cnt_d = cnt_q + {5'd0, push} - {5'd0, pop};
    end
  end

  // Pointer and count registers.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values that were present before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 6'(DEPTH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Tag storage. On reset the list must come up holding tags 32..63, because
  // tags 0..31 are the architectural mappings.
  // NOTE: this array is built from resettable flops, not RAM. Its contents
  // after reset are functionally required, so it cannot be a macro that
  // lacks a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= 7'(DEPTH + i);
      end
    end else if (push) begin
      entry_q[tail_q] <= retire_tag_i;
    end
  end

  // Outputs come straight from state. A tag retired in this cycle does not
  // bypass to free_tag_o.
  assign free_tag_o   = entry_q[head_q];
  assign free_valid_o = (cnt_q != 6'd0);
  assign head_o       = head_q;
  assign free_cnt_o   = cnt_q;
  assign full_o       = (cnt_q == 6'(DEPTH));

endmodule

// File: tb/tb_free_list.sv
// ---------------------------------------------------------------------------
// tb_free_list
//
// Self-checking bench for free_list. The test has three parts:
//   - a table of sequential vectors applied from reset, with hand-derived
//     expected outputs
//   - hand-written sequences for wrap, empty, recovery, full and mid-run reset
//   - randomized traffic compared against a reference model. The model treats
//     the list as a ring of tags with integer head, tail and count.
// ---------------------------------------------------------------------------

`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif

`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module tb_free_list;

  localparam logic [`BR_STATE_W-1:0] BR_NONE  = `BR_STATE_W'(0);
  localparam logic [`BR_STATE_W-1:0] BR_OK    = `BR_STATE_W'(1);
  localparam logic [`BR_STATE_W-1:0] BR_OTHER = `BR_STATE_W'(3);
  localparam logic [`BR_STATE_W-1:0] BR_WRONG = `BR_PR_WRONG;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   dispatch_en;
  logic                   retire_en;
  logic [6:0]             retire_tag;
  logic [`BR_STATE_W-1:0] br_state;
  logic [4:0]             rc_fl_head;
  logic [6:0]             free_tag;
  logic                   free_valid;
  logic [4:0]             head;
  logic [5:0]             free_cnt;
  logic                   full;

  int n_checks = 0;
  int n_errors = 0;

  free_list dut (
    .clk           (clk),
    .rst           (rst),
    .dispatch_en_i (dispatch_en),
    .retire_en_i   (retire_en),
    .retire_tag_i  (retire_tag),
    .br_state_i    (br_state),
    .rc_fl_head_i  (rc_fl_head),
    .free_tag_o    (free_tag),
    .free_valid_o  (free_valid),
    .head_o        (head),
    .free_cnt_o    (free_cnt),
    .full_o        (full)
  );

  always #5 clk = ~clk;

  // Watchdog: the run is fully clock-bounded, but it must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [6:0] e_tag, input logic e_valid,
                            input logic [4:0] e_head, input logic [5:0] e_cnt, input logic e_full);
    check({name, ".free_tag"},   32'(free_tag),   32'(e_tag));
    check({name, ".free_valid"}, 32'(free_valid), 32'(e_valid));
    check({name, ".head"},       32'(head),       32'(e_head));
    check({name, ".free_cnt"},   32'(free_cnt),   32'(e_cnt));
    check({name, ".full"},       32'(full),       32'(e_full));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dispatch_en = 1'b0;
    retire_en   = 1'b0;
    retire_tag  = '0;
    br_state    = BR_NONE;
    rc_fl_head  = '0;
  endtask

  // ---------------- reference model ----------------
  // The list is a ring of 32 tags. The count is tracked directly. Recovery
  // gives back as many tags as the head moved since the checkpoint.
  int m_mem [32];
  int m_head, m_tail, m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 32 + i;
    m_head = 0;
    m_tail = 0;
    m_cnt  = 32;
  endtask

  task automatic model_step(input logic d, input logic r, input int tag,
                            input logic [`BR_STATE_W-1:0] br, input int rc);
    bit do_push, do_pop, rec;
    int k;
    rec     = (br == BR_WRONG);
    do_push = r && (m_cnt < 32);
    do_pop  = d && (m_cnt > 0) && !rec;
    if (do_push) begin
      m_mem[m_tail] = tag;
      m_tail = (m_tail + 1) % 32;
    end
    if (rec) begin
      k      = (m_head - rc + 32) % 32;
      m_head = rc;
      m_cnt  = m_cnt + k + (do_push ? 1 : 0);
    end else begin
      if (do_pop) m_head = (m_head + 1) % 32;
      m_cnt = m_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  task automatic pop_n(input int n);
    dispatch_en = 1'b1;
    repeat (n) tick();
    dispatch_en = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic                   disp;
    logic                   ret;
    logic [6:0]             tag;
    logic [`BR_STATE_W-1:0] br;
    logic [4:0]             rc;
    logic [6:0]             e_tag;
    logic                   e_valid;
    logic [4:0]             e_head;
    logic [5:0]             e_cnt;
    logic                   e_full;
  } vec_t;

  vec_t vecs [10];

  initial begin
    idle_inputs();

    // Sequential vectors, applied one per cycle from reset. Each expected
    // value is the output state after that cycle's edge.
    //          disp  ret   tag     br        rc     e_tag  val   head   cnt    full
    vecs[0] = '{1'b1, 1'b0, 7'd0,   BR_NONE,  5'd0,  7'd33, 1'b1, 5'd1,  6'd31, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 7'd0,   BR_NONE,  5'd0,  7'd34, 1'b1, 5'd2,  6'd30, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 7'd0,   BR_NONE,  5'd0,  7'd35, 1'b1, 5'd3,  6'd29, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 7'd100, BR_NONE,  5'd0,  7'd35, 1'b1, 5'd3,  6'd30, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 7'd101, BR_NONE,  5'd0,  7'd36, 1'b1, 5'd4,  6'd30, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 7'd0,   BR_WRONG, 5'd3,  7'd35, 1'b1, 5'd3,  6'd31, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 7'd0,   BR_WRONG, 5'd3,  7'd35, 1'b1, 5'd3,  6'd31, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 7'd0,   BR_OK,    5'd0,  7'd36, 1'b1, 5'd4,  6'd30, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 7'd7,   BR_NONE,  5'd0,  7'd36, 1'b1, 5'd4,  6'd31, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 7'd0,   BR_OTHER, 5'd9,  7'd37, 1'b1, 5'd5,  6'd30, 1'b0};

    // ---- reset state ----
    do_reset();
    check_outs("reset", 7'd32, 1'b1, 5'd0, 6'd32, 1'b1);

    // ---- table-driven vectors ----
    for (int i = 0; i < 10; i++) begin
      dispatch_en = vecs[i].disp;
      retire_en   = vecs[i].ret;
      retire_tag  = vecs[i].tag;
      br_state    = vecs[i].br;
      rc_fl_head  = vecs[i].rc;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_tag, vecs[i].e_valid,
                 vecs[i].e_head, vecs[i].e_cnt, vecs[i].e_full);
    end
    idle_inputs();

    // ---- drain all 32 entries, head wraps, 33rd pop ignored ----
    do_reset();
    dispatch_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain.tag%0d", i), 32'(free_tag), 32 + i);
      tick();
    end
    check_outs("drained", 7'd32, 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    check_outs("pop_on_empty", 7'd32, 1'b0, 5'd0, 6'd0, 1'b0);

    // ---- empty list: same-cycle push 5 and pop, no bypass ----
    retire_en  = 1'b1;
    retire_tag = 7'd5;
    #1;
    check("empty_no_bypass.valid", 32'(free_valid), 0);
    tick();
    idle_inputs();
    check_outs("empty_push_pop", 7'd5, 1'b1, 5'd0, 6'd1, 1'b0);

    // ---- recovery rewinds head from 6 to 2 ----
    do_reset();
    pop_n(2);
    check_outs("rec.pre2", 7'd34, 1'b1, 5'd2, 6'd30, 1'b0);
    pop_n(4);
    check_outs("rec.pre6", 7'd38, 1'b1, 5'd6, 6'd26, 1'b0);
    br_state   = BR_WRONG;
    rc_fl_head = 5'd2;
    tick();
    idle_inputs();
    check_outs("rec.done", 7'd34, 1'b1, 5'd2, 6'd30, 1'b0);

    // ---- recovery with same-cycle push of tag 9 and dispatch ----
    pop_n(4);
    check_outs("recpush.pre", 7'd38, 1'b1, 5'd6, 6'd26, 1'b0);
    dispatch_en = 1'b1;
    retire_en   = 1'b1;
    retire_tag  = 7'd9;
    br_state    = BR_WRONG;
    rc_fl_head  = 5'd2;
    tick();
    idle_inputs();
    check_outs("recpush.done", 7'd34, 1'b1, 5'd2, 6'd31, 1'b0);
    // Tag 9 went to entry 0 (tail was 0), so 30 pops bring it to the head.
    pop_n(30);
    check_outs("recpush.tag9", 7'd9, 1'b1, 5'd0, 6'd1, 1'b0);
    pop_n(1);
    check_outs("recpush.empty", 7'd33, 1'b0, 5'd1, 6'd0, 1'b0);

    // ---- retire while full is ignored ----
    do_reset();
    retire_en  = 1'b1;
    retire_tag = 7'd77;
    if (full) $display("protocol: retire_en asserted while full (expected to be ignored)");
    tick();
    idle_inputs();
    check_outs("full_push", 7'd32, 1'b1, 5'd0, 6'd32, 1'b1);
    pop_n(1);
    check_outs("full_push.pop", 7'd33, 1'b1, 5'd1, 6'd31, 1'b0);
    // If the ignored push had advanced the tail, this tag would land in
    // entry 1 and not entry 0.
    retire_en  = 1'b1;
    retire_tag = 7'd50;
    tick();
    idle_inputs();
    check_outs("full_push.refill", 7'd33, 1'b1, 5'd1, 6'd32, 1'b1);
    pop_n(31);
    check_outs("full_push.wrap", 7'd50, 1'b1, 5'd0, 6'd1, 1'b0);

    // ---- asynchronous reset in mid-operation ----
    pop_n(1);
    dispatch_en = 1'b1;
    retire_en   = 1'b1;
    retire_tag  = 7'd11;
    br_state    = BR_WRONG;
    rc_fl_head  = 5'd4;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_outs("async_reset", 7'd32, 1'b1, 5'd0, 6'd32, 1'b1);
    idle_inputs();
    model_reset();
    #1;
    rst = 1'b1;
    tick();
    check_outs("after_reset", 7'd32, 1'b1, 5'd0, 6'd32, 1'b1);

    // ---- randomized traffic against the reference model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int  phase;
      int  k, maxk;
      logic d, r;
      logic [`BR_STATE_W-1:0] br;
      int  rc, tag;
      phase = (i / 200) % 2;
      d   = phase == 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r   = phase == 0 ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (m_cnt == 32) r = 1'b0;
      tag = int'($urandom_range(0, 127));
      br  = `BR_STATE_W'($urandom_range(0, 3));
      rc  = 0;
      if ($urandom_range(0, 9) == 0) begin
        // Keep the rewind within what the ROB-depth assumption allows.
        br   = BR_WRONG;
        maxk = 32 - m_cnt - (r ? 1 : 0);
        k    = int'($urandom_range(0, maxk));
        rc   = (m_head - k + 32) % 32;
      end else if (br == BR_WRONG) begin
        br = BR_NONE;
      end
      dispatch_en = d;
      retire_en   = r;
      retire_tag  = 7'(tag);
      br_state    = br;
      rc_fl_head  = 5'(rc);
      model_step(d, r, tag, br, rc);
      tick();
      check_outs($sformatf("rand%0d", i), 7'(m_mem[m_head]), m_cnt != 0,
                 5'(m_head), 6'(m_cnt), m_cnt == 32);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
